// File: rtl/pipe_fifo.sv
// rtl/pipe_fifo.sv - first-word-fall-through FIFO with valid/ready handshakes and synchronous flush
// Pointers carry an extra wrap bit so full and empty are told apart without a separate counter.

module dff_we #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_aL,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

module pipe_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_data,
  output logic [AW:0]      count
);

  logic [AW:0]      head_q, head_d;
  logic [AW:0]      tail_q, tail_d;
  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [DEPTH-1:0] entry_we;
  logic             empty, full;
  logic             enq_fire, deq_fire;

  dff_we #(.W(AW+1)) u_head (
    .clk    (clk),
    .rst_aL (rst_aL),
    .we     (1'b1),
    .d      (head_d),
    .q      (head_q)
  );

  dff_we #(.W(AW+1)) u_tail (
    .clk    (clk),
    .rst_aL (rst_aL),
    .we     (1'b1),
    .d      (tail_d),
    .q      (tail_q)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    dff_we #(.W(WIDTH)) u_entry (
      .clk    (clk),
      .rst_aL (rst_aL),
      .we     (entry_we[i]),
      .d      (enq_data),
      .q      (entry_q[i])
    );
  end

  always_comb begin
    empty     = (head_q == tail_q);
    full      = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    enq_ready = !full;
    deq_valid = !empty;
    deq_data  = entry_q[head_q[AW-1:0]];
    count     = tail_q - head_q;
    enq_fire  = enq_valid && enq_ready;
    deq_fire  = deq_valid && deq_ready;
  end

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    entry_we = '0;
    if (flush) begin
      // Flush wins over any handshake this cycle; the enqueued word is dropped.
      head_d = '0;
      tail_d = '0;
    end else begin
      if (enq_fire) begin
        tail_d = tail_q + 1'b1;
      end
      if (deq_fire) begin
        head_d = head_q + 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        entry_we[i] = enq_fire && (tail_q[AW-1:0] == AW'(i));
      end
    end
  end

endmodule

// File: tb/tb_pipe_fifo.sv
// tb/tb_pipe_fifo.sv - scoreboard bench for pipe_fifo (WIDTH=8, DEPTH=4)

module tb_pipe_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk;
  logic             rst_aL;
  logic             flush;
  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_data;
  logic             deq_valid;
  logic             deq_ready;
  logic [WIDTH-1:0] deq_data;
  logic [AW:0]      count;

  int checks;
  int failures;
  logic [WIDTH-1:0] sb [$];

  pipe_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_aL    (rst_aL),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_data  (enq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_data  (deq_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drive inputs, check outputs against the model, update the model, advance.
  task automatic drive(input logic ev, input logic [WIDTH-1:0] ed, input logic dr, input logic fl);
    bit exp_enq, exp_deq;
    int sz;
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    flush     = fl;
    #1;
    sz = sb.size();
    chk("count", 32'(count), 32'(sz));
    chk("enq_ready", 32'(enq_ready), 32'(sz < DEPTH));
    chk("deq_valid", 32'(deq_valid), 32'(sz > 0));
    if (sz > 0) chk("deq_data", 32'(deq_data), 32'(sb[0]));
    exp_enq = ev && (sz < DEPTH);
    exp_deq = dr && (sz > 0);
    if (fl) begin
      sb.delete();
    end else begin
      if (exp_deq) void'(sb.pop_front());
      if (exp_enq) sb.push_back(ed);
    end
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_aL = 1'b0;
    #1;
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_deq_data", 32'(deq_data), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_aL = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_data  = '0;
    deq_ready = 1'b0;
    rst_aL    = 1'b1;
    @(negedge clk);
    reset_pulse();

    // First enqueue after reset appears one cycle later
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill to full, refused fifth enqueue, then full with dequeue
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 8'h66, 1'b1, 1'b0);
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    repeat (5) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming through several pointer wraps
    for (int i = 0; i < 20; i++) drive(1'b1, 8'(i), 1'b1, 1'b0);
    repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with concurrent enqueue and dequeue
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    drive(1'b1, 8'hA2, 1'b0, 1'b0);
    drive(1'b1, 8'hA3, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 8'h88, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a clock phase with data present
    drive(1'b1, 8'hB1, 1'b0, 1'b0);
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    #3;
    reset_pulse();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Random backpressure; data is unknown whenever enq_valid is low
    for (int i = 0; i < 10000; i++) begin
      logic ev, dr;
      logic [WIDTH-1:0] ed;
      ev = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      ed = ev ? 8'($urandom) : 8'bx;
      drive(ev, ed, dr, 1'b0);
    end
    repeat (5) drive(1'b0, 8'h00, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_fifo.md
Name: pipe_fifo

Overview:
- Parameterized first-word-fall-through FIFO with valid/ready handshakes on both sides, used as the elastic buffer between pipeline stages (e.g. fetch→decode instruction queue, dispatch→issue).
- Storage entries and pointers are built from `register` / `dff_we` instances sharing `clk` and `rst_aL`.
- Adds a synchronous flush for branch-mispredict recovery.

Parameters:
- WIDTH, 32, payload bits per entry.
- DEPTH, 4, number of entries; must be a power of two and ≥2.
- (derived) AW = log2(DEPTH), the pointer index width.

Ports:
- clk  input  1  rising-edge clock.
- rst_aL  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous clear of all entries.
- enq_valid  input  1  upstream has data.
- enq_ready  output  1  FIFO can accept this cycle.
- enq_data  input  WIDTH  upstream payload.
- deq_valid  output  1  head entry is valid.
- deq_ready  input  1  downstream consumes the head this cycle.
- deq_data  output  WIDTH  head payload.
- count  output  AW+1  occupied entries, range 0..DEPTH.

Behaviour:
- **State.** The FIFO holds:
  - head and tail pointers, each AW+1 bits wide (the MSB is a wrap bit);
  - DEPTH entry registers of WIDTH bits each, with a per-entry write enable.
- **Full/empty and handshake outputs.**
  - empty = (head == tail).
  - full = (index bits equal) && (wrap bits differ).
  - enq_ready = !full, purely combinational from state; it does not depend on enq_valid, deq_ready or flush.
  - deq_valid = !empty.
  - deq_data = entry[head index], combinational (FWFT).
  - count = tail − head, modulo 2^(AW+1).
- **Enqueue fire** = enq_valid && enq_ready. At the clock edge:
  - enq_data is written to entry[tail index];
  - tail advances by 1 and wraps naturally through the AW+1 bits.
- **Dequeue fire** = deq_valid && deq_ready. At the clock edge, head advances by 1.
- **Simultaneous enqueue and dequeue fire:**
  - both pointers advance and count is unchanged;
  - when DEPTH−1 entries are occupied, the write lands in the last free slot;
  - when full, enq_ready=0, so an enqueue cannot fire in the same cycle as a dequeue. There is no same-cycle full bypass.
- **Empty FIFO, no bypass:**
  - An enqueue into an empty FIFO gives deq_valid=1 on the next cycle, with deq_data equal to the written value.
  - deq_ready while empty has no effect.
- **Latency.** Minimum enqueue-to-dequeue latency is 1 cycle. Throughput is 1 item per cycle when neither full nor empty.
- **Flush:**
  - At the clock edge, head and tail are set to 0; the next cycle has count=0, deq_valid=0, enq_ready=1.
  - Flush overrides any enqueue or dequeue fire in the same cycle; the enqueue is discarded.
  - Handshake outputs during the flush cycle still reflect the pre-flush state.
  - Entry contents are not cleared by flush.
- **Reset (rst_aL=0):**
  - Immediate and asynchronous, independent of clk.
  - Pointers are set to 0 and all entries to 0.
  - Outputs while reset is held: enq_ready=1, deq_valid=0, deq_data=0, count=0.
  - Reset asserted mid-stream discards all contents.
  - Operation resumes on the first rising edge after rst_aL goes high.
- **Input rules.**
  - enq_data is sampled only on an enqueue fire.
  - X on enq_data when enq_valid=0 must not propagate to any state.

Test Plan:
- **Reset:** hold rst_aL=0 for 2 cycles mid-clock → enq_ready=1, deq_valid=0, count=0, deq_data=0 immediately (asynchronous). Release → first enqueue of 0xA5 gives deq_valid=1, deq_data=0xA5 one cycle later.
- **Fill to full** (WIDTH=8, DEPTH=4): enqueue 0x11, 0x22, 0x33, 0x44 with deq_ready=0.
  - Expect count = 1, 2, 3, 4, then enq_ready=0.
  - A fifth enqueue of 0x55 is not accepted.
  - Drain → 0x11, 0x22, 0x33, 0x44 in order, then deq_valid=0.
- **Wrap-around streaming:** enq_valid=deq_ready=1 for 20 cycles with an incrementing payload 0x00..0x13.
  - count settles to 1.
  - Output sequence is exact and in order through 5 pointer wraps.
- **Full simultaneous:** with FIFO full and deq_ready=1, enq_valid=1 (0x66) → only the dequeue fires (head 0x11 out), count=3. Next cycle the enqueue is accepted, count=4 (dequeue continues as deq_ready allows).
- **Flush:** with 3 entries present, assert flush together with enq_valid=1 (0x77) and deq_ready=1 → next cycle count=0, deq_valid=0, and 0x77 never appears at deq_data.
- **Backpressure / random:** randomized enq_valid/deq_ready at 50%, 10k cycles, checked against a scoreboard queue → zero mismatches, count always equals the scoreboard size, never exceeds 4.
